// File: rtl/display_timing_pipe.sv
// Display timing generator: free-running h/v counters, sync and display-enable
// generation, a programmable-latency alignment delay line and colour blanking.
module display_timing_pipe #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int RGB_LAT  = 0,
  parameter int CW       = 4,
  parameter int XY_W     = 11
) (
  input  logic            clk_25,
  input  logic            reset,
  input  logic [CW-1:0]   Red_level,
  input  logic [CW-1:0]   Green_level,
  input  logic [CW-1:0]   Blue_level,
  output logic [XY_W-1:0] pxl_x,
  output logic [XY_W-1:0] pxl_y,
  output logic            disp_ena,
  output logic            line_start,
  output logic            frame_start,
  output logic [15:0]     frame_cnt,
  output logic [CW-1:0]   Red,
  output logic [CW-1:0]   Green,
  output logic [CW-1:0]   Blue,
  output logic            h_sync,
  output logic            v_sync
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Reject illegal configurations at elaboration time.
  generate
    if (RGB_LAT < 0 || RGB_LAT > 8) begin : g_bad_lat
      $fatal(1, "display_timing_pipe: RGB_LAT out of range 0..8");
    end
    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_field
      $fatal(1, "display_timing_pipe: timing fields must be non-zero");
    end
    if (XY_W < 1 || XY_W > 30 ||
        (H_TOTAL - 1) >= (1 << XY_W) || (V_TOTAL - 1) >= (1 << XY_W)) begin : g_bad_width
      $fatal(1, "display_timing_pipe: XY_W too narrow for the totals");
    end
    if (CW < 1) begin : g_bad_cw
      $fatal(1, "display_timing_pipe: CW must be at least 1");
    end
  endgenerate

  localparam logic [XY_W-1:0] X_LAST   = XY_W'(H_TOTAL - 1);
  localparam logic [XY_W-1:0] Y_LAST   = XY_W'(V_TOTAL - 1);
  localparam logic [XY_W-1:0] X_ACT    = XY_W'(H_ACTIVE);
  localparam logic [XY_W-1:0] Y_ACT    = XY_W'(V_ACTIVE);
  localparam logic [XY_W-1:0] HS_FIRST = XY_W'(H_ACTIVE + H_FP);
  localparam logic [XY_W-1:0] HS_LAST  = XY_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [XY_W-1:0] VS_FIRST = XY_W'(V_ACTIVE + V_FP);
  localparam logic [XY_W-1:0] VS_LAST  = XY_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [XY_W-1:0] x_q, x_d;
  logic [XY_W-1:0] y_q, y_d;
  logic [15:0]     frame_q, frame_d;
  logic            end_of_line, end_of_frame;

  always_comb begin
    end_of_line  = (x_q == X_LAST);
    end_of_frame = (y_q == Y_LAST);
    x_d          = end_of_line ? '0 : x_q + XY_W'(1);
    y_d          = y_q;
    frame_d      = frame_q;
    if (end_of_line) begin
      y_d = end_of_frame ? '0 : y_q + XY_W'(1);
      if (end_of_frame) begin
        frame_d = frame_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_25) begin
    if (reset) begin
      x_q     <= '0;
      y_q     <= '0;
      frame_q <= '0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      frame_q <= frame_d;
    end
  end

  logic hs_raw, vs_raw, de_raw;

  // Vertical sync depends only on y, so it naturally changes with x == 0.
  always_comb begin
    hs_raw = (x_q >= HS_FIRST) && (x_q <= HS_LAST);
    vs_raw = (y_q >= VS_FIRST) && (y_q <= VS_LAST);
    de_raw = (x_q < X_ACT) && (y_q < Y_ACT);
  end

  logic [2:0] stage_out;

  generate
    if (RGB_LAT == 0) begin : g_no_delay
      assign stage_out = {hs_raw, vs_raw, de_raw};
    end else begin : g_delay
      logic [2:0] pipe_q [RGB_LAT];

      always_ff @(posedge clk_25) begin
        if (reset) begin
          for (int i = 0; i < RGB_LAT; i++) begin
            pipe_q[i] <= 3'b000;
          end
        end else begin
          pipe_q[0] <= {hs_raw, vs_raw, de_raw};
          for (int i = 1; i < RGB_LAT; i++) begin
            pipe_q[i] <= pipe_q[i-1];
          end
        end
      end

      assign stage_out = pipe_q[RGB_LAT-1];
    end
  endgenerate

  logic hs_dly, vs_dly, de_dly;

  // Gating with reset keeps pins inactive even on the combinational path.
  always_comb begin
    {hs_dly, vs_dly, de_dly} = reset ? 3'b000 : stage_out;
  end

  always_comb begin
    pxl_x       = x_q;
    pxl_y       = y_q;
    disp_ena    = de_raw;
    frame_cnt   = frame_q;
    line_start  = !reset && (x_q == '0);
    frame_start = !reset && (x_q == '0) && (y_q == '0);
    h_sync      = hs_dly ? H_POL : ~H_POL;
    v_sync      = vs_dly ? V_POL : ~V_POL;
    Red         = de_dly ? Red_level   : '0;
    Green       = de_dly ? Green_level : '0;
    Blue        = de_dly ? Blue_level  : '0;
  end

endmodule

// File: tb/tb_display_timing_pipe.sv
// Bench for display_timing_pipe: a latency-2 active-low instance and a
// latency-0 active-high instance run side by side against an arithmetic model.
module tb_display_timing_pipe;

  localparam int HT = 15;
  localparam int VT = 8;
  localparam int FT = HT * VT;

  logic        clk_25 = 1'b0;
  logic        reset;
  logic [3:0]  Red_level, Green_level, Blue_level;

  logic [10:0] aX, aY, bX, bY;
  logic        aDe, aLs, aFs, aHs, aVs, bDe, bLs, bFs, bHs, bVs;
  logic [15:0] aFc, bFc;
  logic [3:0]  aR, aG, aB, bR, bG, bB;

  int compared   = 0;
  int mismatched = 0;
  int n          = 0;

  always #5 clk_25 = ~clk_25;

  display_timing_pipe #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_POL(1'b0), .V_POL(1'b0), .RGB_LAT(2), .CW(4), .XY_W(11)
  ) u_dutA (
    .clk_25(clk_25), .reset(reset),
    .Red_level(Red_level), .Green_level(Green_level), .Blue_level(Blue_level),
    .pxl_x(aX), .pxl_y(aY), .disp_ena(aDe), .line_start(aLs), .frame_start(aFs),
    .frame_cnt(aFc), .Red(aR), .Green(aG), .Blue(aB), .h_sync(aHs), .v_sync(aVs)
  );

  display_timing_pipe #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b1), .RGB_LAT(0), .CW(4), .XY_W(11)
  ) u_dutB (
    .clk_25(clk_25), .reset(reset),
    .Red_level(Red_level), .Green_level(Green_level), .Blue_level(Blue_level),
    .pxl_x(bX), .pxl_y(bY), .disp_ena(bDe), .line_start(bLs), .frame_start(bFs),
    .frame_cnt(bFc), .Red(bR), .Green(bG), .Blue(bB), .h_sync(bHs), .v_sync(bVs)
  );

  // Model: n is the number of clocks since the last reset edge.
  function automatic bit hsRaw(int m);
    return (m % HT) >= 10 && (m % HT) <= 12;
  endfunction

  function automatic bit vsRaw(int m);
    return ((m / HT) % VT) >= 5 && ((m / HT) % VT) <= 6;
  endfunction

  function automatic bit deRaw(int m);
    return (m % HT) < 8 && ((m / HT) % VT) < 4;
  endfunction

  function automatic bit delayed(int kind, int lat);
    if (reset || n < lat) return 1'b0;
    case (kind)
      0:       return hsRaw(n - lat);
      1:       return vsRaw(n - lat);
      default: return deRaw(n - lat);
    endcase
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s at n=%0d: observed=%0h expected=%0h", tag, n, obs, exp);
    end
  endtask

  task automatic checkOutput();
    int  ex, ey;
    bit  deA, deB;
    ex  = n % HT;
    ey  = (n / HT) % VT;
    deA = delayed(2, 2);
    deB = delayed(2, 0);
    checkVal("A.pxl_x", 32'(aX), 32'(ex));
    checkVal("A.pxl_y", 32'(aY), 32'(ey));
    checkVal("B.pxl_x", 32'(bX), 32'(ex));
    checkVal("B.pxl_y", 32'(bY), 32'(ey));
    checkVal("A.disp_ena", 32'(aDe), 32'(deRaw(n)));
    checkVal("B.disp_ena", 32'(bDe), 32'(deRaw(n)));
    checkVal("A.line_start", 32'(aLs), 32'(!reset && ex == 0));
    checkVal("A.frame_start", 32'(aFs), 32'(!reset && (n % FT) == 0));
    checkVal("B.frame_start", 32'(bFs), 32'(!reset && (n % FT) == 0));
    checkVal("A.frame_cnt", 32'(aFc), 32'((n / FT) % 65536));
    checkVal("B.frame_cnt", 32'(bFc), 32'((n / FT) % 65536));
    checkVal("A.h_sync", 32'(aHs), 32'(!delayed(0, 2)));
    checkVal("A.v_sync", 32'(aVs), 32'(!delayed(1, 2)));
    checkVal("B.h_sync", 32'(bHs), 32'(delayed(0, 0)));
    checkVal("B.v_sync", 32'(bVs), 32'(delayed(1, 0)));
    checkVal("A.Red",   32'(aR), deA ? 32'(Red_level)   : 32'd0);
    checkVal("A.Green", 32'(aG), deA ? 32'(Green_level) : 32'd0);
    checkVal("A.Blue",  32'(aB), deA ? 32'(Blue_level)  : 32'd0);
    checkVal("B.Red",   32'(bR), deB ? 32'(Red_level)   : 32'd0);
    checkVal("B.Blue",  32'(bB), deB ? 32'(Blue_level)  : 32'd0);
  endtask

  // One clock: advance the model at the edge, then drive new inputs and check.
  task automatic applyStimulus(input bit nextReset, input bit randomColour);
    @(posedge clk_25);
    if (reset) n = 0;
    else       n = n + 1;
    #1;
    reset = nextReset;
    if (randomColour) begin
      Red_level   = 4'($urandom_range(0, 15));
      Green_level = 4'($urandom_range(0, 15));
      Blue_level  = 4'($urandom_range(0, 15));
    end else begin
      Red_level   = 4'hF;
      Green_level = 4'hA;
      Blue_level  = 4'h5;
    end
    @(negedge clk_25);
    checkOutput();
  endtask

  initial begin
    reset       = 1'b1;
    Red_level   = 4'hF;
    Green_level = 4'hA;
    Blue_level  = 4'h5;

    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    $display("[TB] reset released, free running");

    for (int i = 0; i < 120; i++) applyStimulus(1'b0, 1'b0);
    for (int i = 0; i < 275; i++) applyStimulus(1'b0, 1'b1);

    $display("[TB] mid-frame reset at pxl_x=6 pxl_y=2");
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1);
    for (int i = 0; i < 150; i++) applyStimulus(1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
